// File: rtl/z16_decode_stage.sv
// Z16 decode stage: decodes one instruction per cycle and stalls on RAW (optionally WAW) scoreboard hazards.
// Latency: one cycle from accept to o_valid; a same-cycle writeback releases a stall with no bubble.
// Backpressure: holds the decode while i_ready=0; o_ready drops on hazard, reset or a held, unconsumed decode.
module z16_decode_stage #(
    parameter int XLEN      = 16,
    parameter bit STALL_WAW = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [15:0]     i_instr,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [3:0]      o_opecode,
    output logic [3:0]      o_rd_addr,
    output logic [3:0]      o_rs1_addr,
    output logic [3:0]      o_rs2_addr,
    output logic [XLEN-1:0] o_imm,
    output logic            o_rd_wen,
    output logic            o_mem_wen,
    output logic [3:0]      o_alu_ctrl,
    input  logic            i_wb_en,
    input  logic [3:0]      i_wb_addr,
    input  logic            i_flush,
    output logic [15:0]     o_pending
);
    typedef struct packed {
        logic [3:0]      opecode;
        logic [3:0]      rd_addr;
        logic [3:0]      rs1_addr;
        logic [3:0]      rs2_addr;
        logic [XLEN-1:0] imm;
        logic            rd_wen;
        logic            mem_wen;
        logic [3:0]      alu_ctrl;
    } dec_t;

    dec_t        dec;
    dec_t        hold_q;
    logic        valid_q;
    logic        uses_rs2;
    logic        hazard;
    logic        accept;
    logic [15:0] pending_q;
    logic [15:0] wb_clr;
    logic [15:0] flush_clr;
    logic [15:0] acc_set;
    logic [15:0] eff;

    always_comb begin
        dec          = '0;
        uses_rs2     = 1'b1;
        dec.opecode  = i_instr[3:0];
        dec.rd_addr  = i_instr[7:4];
        dec.rs1_addr = (i_instr[3:0] == 4'h9) ? i_instr[7:4] : i_instr[11:8];
        dec.rs2_addr = i_instr[15:12];
        case (i_instr[3:0])
            4'h9: begin
                dec.rd_wen = 1'b1;
                dec.imm    = XLEN'($signed(i_instr[15:8]));
                uses_rs2   = 1'b0;
            end
            4'hA: begin
                dec.rd_wen = 1'b1;
                dec.imm    = XLEN'($signed(i_instr[15:12]));
                uses_rs2   = 1'b0;
            end
            4'hB: begin
                dec.mem_wen = 1'b1;
                dec.imm     = XLEN'($signed(i_instr[7:4]));
            end
            4'hC, 4'hD, 4'hE, 4'hF: begin
                dec.rd_wen = 1'b0;
            end
            default: begin
                dec.rd_wen   = 1'b1;
                dec.alu_ctrl = i_instr[3:0];
            end
        endcase
    end

    // A writeback in this cycle already counts as retired for hazard purposes.
    assign wb_clr = i_wb_en ? (16'h0001 << i_wb_addr) : 16'h0000;
    assign eff    = pending_q & ~wb_clr;

    assign hazard = eff[dec.rs1_addr]
                  | (uses_rs2 & eff[dec.rs2_addr])
                  | (STALL_WAW & dec.rd_wen & eff[dec.rd_addr]);

    assign o_ready = !i_rst & !hazard & (!valid_q | i_ready);
    assign accept  = i_valid & o_ready & !i_flush;

    assign flush_clr = (i_flush & valid_q & hold_q.rd_wen) ? (16'h0001 << hold_q.rd_addr) : 16'h0000;
    assign acc_set   = (accept & dec.rd_wen) ? (16'h0001 << dec.rd_addr) : 16'h0000;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q <= 16'h0000;
            valid_q   <= 1'b0;
            hold_q    <= '0;
        end else begin
            pending_q <= (pending_q & ~(wb_clr | flush_clr)) | acc_set;
            if (i_flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (i_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                hold_q <= dec;
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_opecode  = hold_q.opecode;
    assign o_rd_addr  = hold_q.rd_addr;
    assign o_rs1_addr = hold_q.rs1_addr;
    assign o_rs2_addr = hold_q.rs2_addr;
    assign o_imm      = hold_q.imm;
    assign o_rd_wen   = hold_q.rd_wen;
    assign o_mem_wen  = hold_q.mem_wen;
    assign o_alu_ctrl = hold_q.alu_ctrl;
    assign o_pending  = pending_q;
endmodule

// File: tb/tb_z16_decode_stage.sv
// Bench for z16_decode_stage: vector table, hand-written hazard/flush/backpressure sequences, random vs. reference model.
module tb_z16_decode_stage;
    localparam int XLEN = 32;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_instr = 16'h0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        i_wb_en = 1'b0;
    logic [3:0]  i_wb_addr = 4'h0;
    logic        i_flush = 1'b0;

    logic            o_ready, o_valid, o_rd_wen, o_mem_wen;
    logic [3:0]      o_opecode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl;
    logic [XLEN-1:0] o_imm;
    logic [15:0]     o_pending;

    logic            n_ready, n_valid, n_rd_wen, n_mem_wen;
    logic [3:0]      n_opecode, n_rd_addr, n_rs1_addr, n_rs2_addr, n_alu_ctrl;
    logic [XLEN-1:0] n_imm;
    logic [15:0]     n_pending;

    z16_decode_stage #(.XLEN(XLEN), .STALL_WAW(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_valid(i_valid), .o_ready(o_ready),
        .i_ready(i_ready), .o_valid(o_valid), .o_opecode(o_opecode), .o_rd_addr(o_rd_addr),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_imm(o_imm), .o_rd_wen(o_rd_wen),
        .o_mem_wen(o_mem_wen), .o_alu_ctrl(o_alu_ctrl), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
        .i_flush(i_flush), .o_pending(o_pending)
    );

    z16_decode_stage #(.XLEN(XLEN), .STALL_WAW(1'b0)) dut_nw (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_valid(i_valid), .o_ready(n_ready),
        .i_ready(i_ready), .o_valid(n_valid), .o_opecode(n_opecode), .o_rd_addr(n_rd_addr),
        .o_rs1_addr(n_rs1_addr), .o_rs2_addr(n_rs2_addr), .o_imm(n_imm), .o_rd_wen(n_rd_wen),
        .o_mem_wen(n_mem_wen), .o_alu_ctrl(n_alu_ctrl), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
        .i_flush(i_flush), .o_pending(n_pending)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: decode from the opcode-class rules, scoreboard as a plain bit array.
    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic        rd_wen;
        logic        mem_wen;
        logic        u2;
        logic [3:0]  alu;
    } mdec_t;

    logic [15:0] m_pend  = 16'h0;
    logic        m_valid = 1'b0;
    mdec_t       m_hold  = '0;
    logic        check_model = 1'b0;
    logic        last_ready;
    logic        last_n_ready;

    function automatic mdec_t ref_decode(input logic [15:0] ins);
        mdec_t d;
        int    op;
        int    v;
        op        = int'(ins[3:0]);
        d         = '0;
        d.opc     = ins[3:0];
        d.rd      = ins[7:4];
        d.rs2     = ins[15:12];
        d.rs1     = (op == 9) ? ins[7:4] : ins[11:8];
        d.rd_wen  = (op <= 10);
        d.mem_wen = (op == 11);
        d.alu     = (op <= 8) ? ins[3:0] : 4'h0;
        d.u2      = !(op == 9 || op == 10);
        v = 0;
        if (op == 9) begin
            v = int'(ins[15:8]);
            if (v >= 128) v -= 256;
        end else if (op == 10) begin
            v = int'(ins[15:12]);
            if (v >= 8) v -= 16;
        end else if (op == 11) begin
            v = int'(ins[7:4]);
            if (v >= 8) v -= 16;
        end
        d.imm = 32'(v);
        return d;
    endfunction

    function automatic logic model_ready();
        mdec_t       d;
        logic [15:0] e;
        logic        haz;
        if (i_rst) return 1'b0;
        d = ref_decode(i_instr);
        e = m_pend;
        if (i_wb_en) e[i_wb_addr] = 1'b0;
        haz = e[d.rs1] || (d.u2 && e[d.rs2]) || (d.rd_wen && e[d.rd]);
        return !haz && (!m_valid || i_ready);
    endfunction

    task automatic model_update(input logic rdy);
        mdec_t       d;
        logic [15:0] np;
        logic        acc;
        d = ref_decode(i_instr);
        if (i_rst) begin
            m_pend  = 16'h0;
            m_valid = 1'b0;
            m_hold  = '0;
        end else begin
            np = m_pend;
            if (i_wb_en) np[i_wb_addr] = 1'b0;
            if (i_flush && m_valid && m_hold.rd_wen) np[m_hold.rd] = 1'b0;
            acc = i_valid && rdy && !i_flush;
            if (acc && d.rd_wen) np[d.rd] = 1'b1;
            m_pend = np;
            if (i_flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                m_hold  = d;
            end else if (i_ready) m_valid = 1'b0;
        end
    endtask

    // Inputs are set at a negedge; o_ready is sampled 1ns later, registered outputs at the next negedge.
    task automatic step();
        logic exp_rdy;
        exp_rdy = model_ready();
        #1;
        last_ready   = o_ready;
        last_n_ready = n_ready;
        if (check_model) chk("rand_ready", 32'(o_ready), 32'(exp_rdy));
        @(posedge i_clk);
        model_update(exp_rdy);
        @(negedge i_clk);
        if (check_model) begin
            chk("rand_valid",   32'(o_valid),    32'(m_valid));
            chk("rand_pending", 32'(o_pending),  32'(m_pend));
            chk("rand_opc",     32'(o_opecode),  32'(m_hold.opc));
            chk("rand_rd",      32'(o_rd_addr),  32'(m_hold.rd));
            chk("rand_rs1",     32'(o_rs1_addr), 32'(m_hold.rs1));
            chk("rand_rs2",     32'(o_rs2_addr), 32'(m_hold.rs2));
            chk("rand_imm",     o_imm,           m_hold.imm);
            chk("rand_rd_wen",  32'(o_rd_wen),   32'(m_hold.rd_wen));
            chk("rand_mem_wen", 32'(o_mem_wen),  32'(m_hold.mem_wen));
            chk("rand_alu",     32'(o_alu_ctrl), 32'(m_hold.alu));
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_wb_en = 1'b0; i_ready = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins);
        i_instr = ins; i_valid = 1'b1; i_ready = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  opc, rd, rs1, rs2;
        logic [31:0] imm;
        logic        rd_wen, mem_wen;
        logic [3:0]  alu;
        logic [15:0] pend;
    } vec_t;

    vec_t vec[10];

    initial begin
        vec[0] = '{16'h3210, 4'h0, 4'h1, 4'h2, 4'h3, 32'h00000000, 1'b1, 1'b0, 4'h0, 16'h0002};
        vec[1] = '{16'hF519, 4'h9, 4'h1, 4'h1, 4'hF, 32'hFFFFFFF5, 1'b1, 1'b0, 4'h0, 16'h0002};
        vec[2] = '{16'h800A, 4'hA, 4'h0, 4'h0, 4'h8, 32'hFFFFFFF8, 1'b1, 1'b0, 4'h0, 16'h0001};
        vec[3] = '{16'h007B, 4'hB, 4'h7, 4'h0, 4'h0, 32'h00000007, 1'b0, 1'b1, 4'h0, 16'h0000};
        vec[4] = '{16'h7658, 4'h8, 4'h5, 4'h6, 4'h7, 32'h00000000, 1'b1, 1'b0, 4'h8, 16'h0020};
        vec[5] = '{16'h7FAA, 4'hA, 4'hA, 4'hF, 4'h7, 32'h00000007, 1'b1, 1'b0, 4'h0, 16'h0400};
        vec[6] = '{16'h8F39, 4'h9, 4'h3, 4'h3, 4'h8, 32'hFFFFFF8F, 1'b1, 1'b0, 4'h0, 16'h0008};
        vec[7] = '{16'hC3EF, 4'hF, 4'hE, 4'h3, 4'hC, 32'h00000000, 1'b0, 1'b0, 4'h0, 16'h0000};
        vec[8] = '{16'h9CEB, 4'hB, 4'hE, 4'hC, 4'h9, 32'hFFFFFFFE, 1'b0, 1'b1, 4'h0, 16'h0000};
        vec[9] = '{16'hA3D5, 4'h5, 4'hD, 4'h3, 4'hA, 32'h00000000, 1'b1, 1'b0, 4'h5, 16'h2000};

        @(negedge i_clk);
        // Reset, including a valid instruction offered while reset is high.
        i_rst = 1'b1; i_instr = 16'h0010; i_valid = 1'b1; i_ready = 1'b1;
        step();
        chk("rst_ready", 32'(last_ready), 32'h0);
        step();
        chk("rst_valid",   32'(o_valid),   32'h0);
        chk("rst_pending", 32'(o_pending), 32'h0);
        chk("rst_imm",     o_imm,          32'h0);
        chk("rst_fields",  32'({o_opecode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_rd_wen, o_mem_wen, o_alu_ctrl}), 32'h0);
        i_rst = 1'b0; i_valid = 1'b0;

        for (int k = 0; k < 10; k++) begin
            do_reset();
            issue(vec[k].instr);
            chk("vec_valid",   32'(o_valid),    32'h1);
            chk("vec_opc",     32'(o_opecode),  32'(vec[k].opc));
            chk("vec_rd",      32'(o_rd_addr),  32'(vec[k].rd));
            chk("vec_rs1",     32'(o_rs1_addr), 32'(vec[k].rs1));
            chk("vec_rs2",     32'(o_rs2_addr), 32'(vec[k].rs2));
            chk("vec_imm",     o_imm,           vec[k].imm);
            chk("vec_rd_wen",  32'(o_rd_wen),   32'(vec[k].rd_wen));
            chk("vec_mem_wen", 32'(o_mem_wen),  32'(vec[k].mem_wen));
            chk("vec_alu",     32'(o_alu_ctrl), 32'(vec[k].alu));
            chk("vec_pending", 32'(o_pending),  32'(vec[k].pend));
        end

        // RAW: consumer of r1 stalls until r1 is written back, then enters in that same cycle.
        do_reset();
        issue(16'h0010);
        chk("raw_pend0", 32'(o_pending), 32'h0002);
        i_instr = 16'h0120; i_valid = 1'b1; i_ready = 1'b1;
        step();
        chk("raw_stall1", 32'(last_ready), 32'h0);
        step();
        chk("raw_stall2", 32'(last_ready), 32'h0);
        chk("raw_bubble", 32'(o_valid), 32'h0);
        i_wb_en = 1'b1; i_wb_addr = 4'h1;
        step();
        i_wb_en = 1'b0; i_valid = 1'b0;
        chk("raw_release", 32'(last_ready), 32'h1);
        chk("raw_pend1",   32'(o_pending), 32'h0004);
        chk("raw_valid",   32'(o_valid), 32'h1);
        chk("raw_rd",      32'(o_rd_addr), 32'h2);

        // Backpressure: held decode stays put for three cycles, then the next one enters.
        do_reset();
        issue(16'h3210);
        i_instr = 16'h5430; i_valid = 1'b1; i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_ready", 32'(last_ready), 32'h0);
            chk("bp_valid", 32'(o_valid),    32'h1);
            chk("bp_hold",  32'({o_rd_addr, o_rs1_addr, o_rs2_addr}), 32'h123);
        end
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        chk("bp_enter_ready", 32'(last_ready), 32'h1);
        chk("bp_enter",       32'({o_valid, o_rd_addr, o_rs1_addr, o_rs2_addr}), 32'h1345);
        chk("bp_pending",     32'(o_pending), 32'h000A);

        // Flush: drop held rd=5, keep r1, and ignore the instruction offered alongside.
        do_reset();
        issue(16'h0010);
        issue(16'h0050);
        chk("fl_pend0", 32'(o_pending), 32'h0022);
        i_flush = 1'b1; i_instr = 16'h0060; i_valid = 1'b1; i_ready = 1'b1;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("fl_valid", 32'(o_valid),   32'h0);
        chk("fl_pend1", 32'(o_pending), 32'h0002);
        chk("fl_rd",    32'(o_rd_addr), 32'h5);

        // WAW: second writer of r4 stalls only on the STALL_WAW=1 instance.
        do_reset();
        issue(16'h0040);
        chk("waw_pend_a", 32'(o_pending), 32'h0010);
        chk("waw_pend_b", 32'(n_pending), 32'h0010);
        i_instr = 16'h0041; i_valid = 1'b1; i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        chk("waw_stall",  32'(last_ready),   32'h0);
        chk("waw_pass",   32'(last_n_ready), 32'h1);
        chk("waw_b_out",  32'({n_valid, n_alu_ctrl, n_rd_addr}), 32'h114);
        chk("waw_b_pend", 32'(n_pending), 32'h0010);
        chk("waw_a_out",  32'(o_valid), 32'h0);

        // Random traffic against the reference model.
        do_reset();
        check_model = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            i_rst     = ($urandom_range(0, 99) == 0);
            i_instr   = 16'($urandom);
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 9) < 7);
            i_wb_en   = ($urandom_range(0, 1) == 1);
            i_wb_addr = 4'($urandom_range(0, 15));
            i_flush   = ($urandom_range(0, 19) == 0);
            step();
        end
        check_model = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/z16_decode_stage.md
# z16_decode_stage

Registered, handshaked decode stage for the Z16 core, sitting between instruction fetch and register-read/execute. It decodes one 16-bit Z16 instruction per cycle into register addresses, a sign-extended immediate of parametrised width, write enables and an ALU control code. A per-register scoreboard stalls the instruction on RAW hazards, and optionally on WAW hazards, against instructions still awaiting writeback. A flush input discards the held instruction.

## Interface
- XLEN, 16, datapath/immediate width in bits; legal range is XLEN >= 8.
- STALL_WAW, 1, when 1, also stall an rd-writing instruction whose rd is pending.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_instr  in  16  instruction from fetch.
- i_valid  in  1  i_instr is valid.
- o_ready  out  1  stage accepts i_instr this cycle.
- i_ready  in  1  downstream accepts the held decode.
- o_valid  out  1  held decode valid.
- o_opecode  out  4  opcode, i_instr[3:0].
- o_rd_addr  out  4  destination register, i_instr[7:4].
- o_rs1_addr  out  4  source 1; i_instr[7:4] for opcode 9, otherwise i_instr[11:8].
- o_rs2_addr  out  4  source 2, i_instr[15:12].
- o_imm  out  XLEN  sign-extended immediate.
- o_rd_wen  out  1  register write enable.
- o_mem_wen  out  1  memory write enable.
- o_alu_ctrl  out  4  ALU operation code.
- i_wb_en  in  1  writeback retires a register write.
- i_wb_addr  in  4  register being written back.
- i_flush  in  1  discard the held decode.
- o_pending  out  16  scoreboard vector, for debug.

## Operation
- Opcode classes:
  - 0x0–0x8: R-type. Reads rs1 and rs2. rd_wen=1. alu_ctrl=opcode. imm=0.
  - 0x9: imm8 op. rs1=rd. Reads rs1. rd_wen=1. alu_ctrl=0. imm is i_instr[15:8] sign-extended to XLEN.
  - 0xA: load. Reads rs1. rd_wen=1. alu_ctrl=0. imm is i_instr[15:12] sign-extended.
  - 0xB: store. Reads rs1 and rs2. mem_wen=1. rd_wen=0. alu_ctrl=0. imm is i_instr[7:4] sign-extended.
  - 0xC–0xF: reads rs1 and rs2. rd_wen=0, mem_wen=0, alu_ctrl=0, imm=0.
- Scoreboard: pending[15:0].
  - Effective pending: eff = pending & ~(i_wb_en ? onehot(i_wb_addr) : 0). A same-cycle writeback therefore clears a hazard immediately.
  - hazard = (uses_rs1 & eff[rs1]) | (uses_rs2 & eff[rs2]) | (STALL_WAW & rd_wen & eff[rd]).
- o_ready = !i_rst & !hazard & (!o_valid | i_ready). It is combinational from i_instr, the wb inputs and state.
- Accept (i_valid & o_ready): on the next edge the output registers load the decode and o_valid=1.
  - If rd_wen, pending[rd] is set on the same edge.
  - Pending update: pending_next = (pending & ~clr) | set. A set wins over a clear of the same bit.
- Drain (o_valid & i_ready & no accept): o_valid goes to 0 on the next edge. The decode fields hold their last values.
- i_flush:
  - On the next edge o_valid=0.
  - If the held decode had rd_wen, its pending[rd] bit is cleared. Other pending bits are unaffected, apart from a normal wb clear.
  - Any accept in the same cycle is ignored and sets nothing.
  - o_ready is not gated by i_flush; an upstream handshake during a flush is dropped by design.
- Register 0 is not special; it is tracked like any other register.

## Timing
- Reset, synchronous: o_valid=0, all decode outputs 0, o_pending=16'h0000. o_ready=0 while i_rst=1.
- Latency: one cycle from accept to o_valid. Throughput is one instruction per cycle when there is no hazard and i_ready=1.
- The held decode is stable while o_valid=1 and i_ready=0.
- A writeback arriving in the same cycle as a stalled instruction releases the stall in that cycle, with no bubble.
- Back-to-back dependent instructions:
  - The consumer stalls until i_wb_en for the producer's rd.
  - The producer needs no downstream handshake to mark rd pending; the bit is set on accept.
- Reset asserted mid-stall or mid-handshake: state is cleared on that edge, and any accept in that cycle is discarded.

## Test plan
- Reset, then i_instr=16'h3210 (opcode 0, rd=1, rs1=2, rs2=3) with i_ready=1. The next cycle shows o_valid=1, rd=1, rs1=2, rs2=3, rd_wen=1, alu_ctrl=0, and o_pending=16'h0002.
- Immediates with XLEN=32:
  - 16'hF519 (opcode 9, imm8=0xF5): o_imm=32'hFFFFFFF5, rs1=rd=1.
  - 16'h800A: o_imm=32'hFFFFFFF8.
  - 16'h007B: o_imm=32'h00000007, mem_wen=1, rd_wen=0.
- RAW hazard: 16'h0010 followed by 16'h0120 (rs1=1).
  - o_ready=0 until i_wb_en=1 with i_wb_addr=1.
  - In that same cycle o_ready=1, the instruction is accepted, and the next cycle shows pending[2]=1 and pending[1]=0.
- Backpressure: i_ready=0 for 3 cycles with a valid decode held. The outputs stay constant, o_ready=0, and the second instruction enters on the cycle i_ready returns to 1.
- Flush: the held 16'h0050 (rd=5) is flushed. The next cycle shows o_valid=0 and pending[5]=0, while pending bits from earlier issued instructions are unchanged.
- WAW: with STALL_WAW=1 and pending[4]=1, an incoming rd=4 instruction stalls. With STALL_WAW=0 it is accepted and pending[4] stays 1.
